// File: rtl/hd_dma.sv
// hd_dma: disk <-> memory block mover, two cycles per word (read, then write).
// Optional running checksum of moved words when HD_DMA_CHECKSUM_EN is defined.
module hd_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int DISK_SIZE  = 4096,
  parameter int LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic [DATA_WIDTH-1:0] hd_base,
  input  logic [DATA_WIDTH-1:0] mem_base,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] hd_address,
  output logic                  hd_write_flag,
  output logic [DATA_WIDTH-1:0] hd_wdata,
  input  logic [DATA_WIDTH-1:0] hd_rdata,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef HD_DMA_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [DATA_WIDTH-1:0] hd_base_q, hd_base_d;
  logic [DATA_WIDTH-1:0] mem_base_q, mem_base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] hd_addr_q, hd_addr_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] ck_q, ck_d;

  logic [DATA_WIDTH:0]   end_w;
  logic                  range_bad;
  logic [DATA_WIDTH-1:0] src_addr;
  logic [DATA_WIDTH-1:0] dst_addr;
  logic [DATA_WIDTH-1:0] xfer_w;

  // One extra bit so base + length never wraps before the compare
  assign end_w = {1'b0, hd_base} + (DATA_WIDTH+1)'(length);
  assign range_bad = end_w > (DATA_WIDTH+1)'(DISK_SIZE);

  assign src_addr = (dir_q ? mem_base_q : hd_base_q)
                  + DATA_WIDTH'(idx_q);
  assign dst_addr = (dir_q ? hd_base_q : mem_base_q)
                  + DATA_WIDTH'(idx_q);
  assign xfer_w = dir_q ? mem_rdata : hd_rdata;

  assign busy  = (state_q == RD) || (state_q == WR);
  assign done  = (state_q == DONE);
  assign error = err_q;

  assign hd_write_flag = (state_q == WR) && dir_q;
  assign mem_write     = (state_q == WR) && !dir_q;
  assign hd_wdata  = hd_write_flag ? mem_rdata : '0;
  assign mem_wdata = mem_write ? hd_rdata : '0;

`ifdef HD_DMA_CHECKSUM_EN
  assign checksum = ck_q;
`endif

  // Address outputs hold their last driven value outside RD/WR
  always_comb begin
    hd_address  = hd_addr_q;
    mem_address = mem_addr_q;
    if (state_q == RD) begin
      if (dir_q) mem_address = src_addr;
      else       hd_address  = src_addr;
    end else if (state_q == WR) begin
      if (dir_q) hd_address  = dst_addr;
      else       mem_address = dst_addr;
    end
    hd_addr_d  = hd_address;
    mem_addr_d = mem_address;
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    hd_base_d  = hd_base_q;
    mem_base_d = mem_base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    err_d      = err_q;
    ck_d       = ck_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dir_d      = dir;
          hd_base_d  = hd_base;
          mem_base_d = mem_base;
          len_d      = length;
          idx_d      = '0;
          err_d      = 1'b0;
          ck_d       = '0;
          if (range_bad) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (length == '0) begin
            state_d = DONE;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = WR;
      WR: begin
        ck_d = ck_q + xfer_w;
        if (idx_q == len_q - 1'b1) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      hd_base_q  <= '0;
      mem_base_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      hd_addr_q  <= '0;
      mem_addr_q <= '0;
      ck_q       <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      hd_base_q  <= hd_base_d;
      mem_base_q <= mem_base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      hd_addr_q  <= hd_addr_d;
      mem_addr_q <= mem_addr_d;
      ck_q       <= ck_d;
    end
  end

endmodule

// File: tb/tb_hd_dma.sv
// Directed bench for hd_dma with behavioural disk and memory models.
// Build with +define+HD_DMA_CHECKSUM_EN to also check the checksum.
module tb_hd_dma;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic [31:0] hd_base;
  logic [31:0] mem_base;
  logic [12:0] length;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] hd_address;
  logic        hd_write_flag;
  logic [31:0] hd_wdata;
  logic [31:0] hd_rdata;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef HD_DMA_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] disk [4096];
  logic [31:0] mem  [4096];
  int          n_mw;
  int          n_hw;
  logic        pl_en;
  logic        pl_sel;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  int nvec;
  int nfail;

  hd_dma dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dir          (dir),
    .hd_base      (hd_base),
    .mem_base     (mem_base),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .hd_address   (hd_address),
    .hd_write_flag(hd_write_flag),
    .hd_wdata     (hd_wdata),
    .hd_rdata     (hd_rdata),
    .mem_address  (mem_address),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
`ifdef HD_DMA_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      disk[i] = 32'h0;
      mem[i]  = 32'h0;
    end
  end

  always @(posedge clk) begin
    if (pl_en) begin
      if (pl_sel) mem[pl_addr] <= pl_data;
      else        disk[pl_addr] <= pl_data;
    end
    if (mem_write) begin
      mem[mem_address[11:0]] <= mem_wdata;
      n_mw <= n_mw + 1;
    end
    if (hd_write_flag) begin
      disk[hd_address[11:0]] <= hd_wdata;
      n_hw <= n_hw + 1;
    end
    hd_rdata  <= disk[hd_address[11:0]];
    mem_rdata <= mem[mem_address[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic sel, input logic [11:0] a,
                      input logic [31:0] d);
    pl_en   = 1'b1;
    pl_sel  = sel;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Starts a transfer; optional restart with other params at sample rs_k.
  task automatic run(input logic d, input logic [31:0] hb,
                     input logic [31:0] mb, input logic [12:0] len,
                     input int rs_k, output int k, output int nb);
    start    = 1'b1;
    dir      = d;
    hd_base  = hb;
    mem_base = mb;
    length   = len;
    @(posedge clk);
    #1;
    start = 1'b0;
    k  = 1;
    nb = 0;
    while (done !== 1'b1 && k < 200) begin
      if (busy === 1'b1) nb++;
      if (k == rs_k) begin
        start    = 1'b1;
        dir      = 1'b0;
        hd_base  = 32'd20;
        mem_base = 32'd400;
        length   = 13'd2;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      k++;
    end
  endtask

  int k;
  int nb;
  int mw0;
  int hw0;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dir      = 1'b0;
    hd_base  = '0;
    mem_base = '0;
    length   = '0;
    pl_en    = 1'b0;
    pl_sel   = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;
    n_mw     = 0;
    n_hw     = 0;
    nvec     = 0;
    nfail    = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_error", {31'b0, error}, 32'h0);
    chk("rst_mw", {31'b0, mem_write}, 32'h0);
    chk("rst_hw", {31'b0, hd_write_flag}, 32'h0);
    chk("rst_hdaddr", hd_address, 32'h0);
    chk("rst_memaddr", mem_address, 32'h0);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 8; i++)
      poke(1'b0, 12'(i), 32'hD000_0000 + 32'(i));

    // LOAD 5 words disk[0..4] -> mem[2096..2100]
    mw0 = n_mw;
    hw0 = n_hw;
    run(1'b0, 32'd0, 32'd2096, 13'd5, 0, k, nb);
    chk("load_lat", 32'(k), 32'd11);
    chk("load_busy", 32'(nb), 32'd10);
    chk("load_err", {31'b0, error}, 32'h0);
    chk("load_bsy_dn", {31'b0, busy}, 32'h0);
    chk("load_nmw", 32'(n_mw - mw0), 32'd5);
    chk("load_nhw", 32'(n_hw - hw0), 32'd0);
    for (int i = 0; i < 5; i++)
      chk("load_data", mem[2096 + i], 32'hD000_0000 + 32'(i));
    @(posedge clk);
    #1;
    chk("load_pulse", {31'b0, done}, 32'h0);

    // SAVE mem[100..102] -> disk[4093..4095]
    poke(1'b1, 12'd100, 32'hA);
    poke(1'b1, 12'd101, 32'hB);
    poke(1'b1, 12'd102, 32'hC);
    mw0 = n_mw;
    hw0 = n_hw;
    run(1'b1, 32'd4093, 32'd100, 13'd3, 0, k, nb);
    chk("save_lat", 32'(k), 32'd7);
    chk("save_err", {31'b0, error}, 32'h0);
    chk("save_nhw", 32'(n_hw - hw0), 32'd3);
    chk("save_nmw", 32'(n_mw - mw0), 32'd0);
    @(posedge clk);
    #1;
    chk("save_d0", disk[4093], 32'hA);
    chk("save_d1", disk[4094], 32'hB);
    chk("save_d2", disk[4095], 32'hC);

    // Range error: 4094 + 3 > 4096
    mw0 = n_mw;
    hw0 = n_hw;
    run(1'b1, 32'd4094, 32'd100, 13'd3, 0, k, nb);
    chk("rng_lat", 32'(k), 32'd1);
    chk("rng_err", {31'b0, error}, 32'h1);
    chk("rng_busy", 32'(nb), 32'd0);
    @(posedge clk);
    #1;
    chk("rng_hold", {31'b0, error}, 32'h1);
    chk("rng_nhw", 32'(n_hw - hw0), 32'd0);
    chk("rng_nmw", 32'(n_mw - mw0), 32'd0);
    chk("rng_disk", disk[4094], 32'hB);

    // Zero length also clears the held error
    run(1'b0, 32'd5, 32'd700, 13'd0, 0, k, nb);
    chk("zero_lat", 32'(k), 32'd1);
    chk("zero_err", {31'b0, error}, 32'h0);
    chk("zero_nmw", 32'(n_mw - mw0), 32'd0);

    // 4-word LOAD with a second start while busy
    poke(1'b0, 12'd10, 32'h1010);
    poke(1'b0, 12'd11, 32'h1111);
    poke(1'b0, 12'd12, 32'h1212);
    poke(1'b0, 12'd13, 32'h1313);
    mw0 = n_mw;
    run(1'b0, 32'd10, 32'd300, 13'd4, 3, k, nb);
    chk("ign_lat", 32'(k), 32'd9);
    chk("ign_nmw", 32'(n_mw - mw0), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("ign_data", mem[300 + i], 32'h1010 + 32'(i) * 32'h0101);
    @(posedge clk);
    #1;
    chk("ign_idle", {31'b0, busy}, 32'h0);
    chk("ign_nmw2", 32'(n_mw - mw0), 32'd4);

    // Reset after the 2nd WR of an 8-word LOAD
    poke(1'b1, 12'd502, 32'hDEAD_BEEF);
    mw0      = n_mw;
    start    = 1'b1;
    dir      = 1'b0;
    hd_base  = 32'd0;
    mem_base = 32'd500;
    length   = 13'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_mw", {31'b0, mem_write}, 32'h0);
    chk("arst_maddr", mem_address, 32'h0);
    chk("arst_haddr", hd_address, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_nmw", 32'(n_mw - mw0), 32'd2);
    chk("arst_m0", mem[500], 32'hD000_0000);
    chk("arst_m1", mem[501], 32'hD000_0001);
    chk("arst_m2", mem[502], 32'hDEAD_BEEF);
    rst_n = 1'b1;
    #1;
    mw0 = n_mw;
    run(1'b0, 32'd5, 32'd510, 13'd3, 0, k, nb);
    chk("post_lat", 32'(k), 32'd7);
    chk("post_nmw", 32'(n_mw - mw0), 32'd3);
    chk("post_m2", mem[512], 32'hD000_0007);

`ifdef HD_DMA_CHECKSUM_EN
    poke(1'b0, 12'd30, 32'h1);
    poke(1'b0, 12'd31, 32'h2);
    poke(1'b0, 12'd32, 32'h3);
    poke(1'b0, 12'd33, 32'hFFFF_FFFF);
    run(1'b0, 32'd30, 32'd600, 13'd4, 0, k, nb);
    chk("ck_lat", 32'(k), 32'd9);
    chk("ck_sum", checksum, 32'h0000_0005);
    @(posedge clk);
    #1;
    chk("ck_hold", checksum, 32'h0000_0005);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
